// File: rtl/led_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Leading-zero blanking helper is used only when LED_LZB_EN is defined.
package led_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StOn,
    StOff
  } scan_state_e;

  localparam int unsigned N_DIG = 6;
  localparam logic [7:0]  SEG_OFF = 8'hFF;
  localparam logic [5:0]  AN_OFF  = 6'h3F;

  // Active-low gfedcba patterns, entry 15 first so SEG_TABLE[hex] indexes directly.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Digit k blanks when it and every higher digit hold a bare zero; digit 0 never blanks.
  function automatic logic [N_DIG-1:0] lzb_mask(input logic [N_DIG-1:0][4:0] codes);
    logic run;
    run      = 1'b1;
    lzb_mask = '0;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      run         = run & (codes[k] == 5'd0);
      lzb_mask[k] = run;
    end
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational {dp, hex} to active-low {dp, g..a} segment decoder.
module hex_to_seg
  import led_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~code_i[4], SEG_TABLE[code_i[3:0]]};

endmodule

// File: rtl/led_scan_ctrl.sv
// Six-digit multiplexed seven-segment scanner with dead-time and duty brightness.
// Define LED_LZB_EN to enable leading-zero blanking.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE = 50_000,
  parameter int unsigned BLANK    = 500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [2:0] bright_i,
  input  logic [4:0] in0_i,
  input  logic [4:0] in1_i,
  input  logic [4:0] in2_i,
  input  logic [4:0] in3_i,
  input  logic [4:0] in4_i,
  input  logic [4:0] in5_i,
  output logic [5:0] an_o,
  output logic [7:0] seg_o,
  output logic [2:0] cur_dig_o,
  output logic       scan_tick_o
);

  localparam int unsigned     CntW      = $clog2(PRESCALE);
  localparam int unsigned     Sub       = (PRESCALE - BLANK) / 8;
  localparam logic [CntW-1:0] CntLast   = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK - 1);

  scan_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            dig_q, dig_d;
  logic [2:0]            bright_q, bright_d;
  logic [4:0]            hold_q, hold_d;
  logic [5:0]            an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  tick_q, tick_d;
  logic [N_DIG-1:0][4:0] codes;
  logic [N_DIG-1:0]      blank_mask;
  logic [CntW-1:0]       on_last;
  logic [7:0]            seg_dec;
  logic                  slot_start;

  assign codes   = {in5_i, in4_i, in3_i, in2_i, in1_i, in0_i};
  assign on_last = CntW'(BLANK + (32'(bright_q) + 32'd1) * Sub - 1);

  hex_to_seg u_dec (
    .code_i(hold_q),
    .seg_o (seg_dec)
  );

`ifdef LED_LZB_EN
  logic [N_DIG-1:0][4:0] snap_q, snap_d;

  // Snapshot at the start of the leftmost slot keeps blanking stable for a whole frame.
  always_comb begin
    snap_d = snap_q;
    if (slot_start && (dig_d == 3'(N_DIG - 1) || state_q == StIdle)) snap_d = codes;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) snap_q <= '0;
    else       snap_q <= snap_d;
  end

  assign blank_mask = lzb_mask(snap_q);
`else
  assign blank_mask = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
      dig_d = '0;
      if (en_i) state_d = StBlank;
    end else if (!en_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      dig_d   = '0;
    end else begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        dig_d = (dig_q == 3'(N_DIG - 1)) ? 3'd0 : dig_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      case (state_q)
        StBlank: if (cnt_q == BlankLast) state_d = StOn;
        // Slot end wins when full brightness makes the on-time reach the slot boundary.
        StOn: begin
          if (cnt_q == CntLast)      state_d = StBlank;
          else if (cnt_q == on_last) state_d = StOff;
        end
        StOff:   if (cnt_q == CntLast) state_d = StBlank;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are computed from next-state so the registered values line up with cnt_q.
  always_comb begin
    slot_start = (state_d != StIdle) && (cnt_d == '0);
    hold_d     = slot_start ? codes[dig_d] : hold_q;
    bright_d   = slot_start ? bright_i : bright_q;
    tick_d     = slot_start;
    an_d       = (state_d == StOn) ? ~(6'b1 << dig_d) : AN_OFF;
    seg_d      = seg_dec;
    if (state_d == StIdle || blank_mask[dig_q]) seg_d = SEG_OFF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dig_q    <= '0;
      bright_q <= '0;
      hold_q   <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      bright_q <= bright_d;
      hold_q   <= hold_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      tick_q   <= tick_d;
    end
  end

  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign cur_dig_o   = dig_q;
  assign scan_tick_o = tick_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized bench for led_scan_ctrl against a slot-timeline reference model.
module tb_led_scan_ctrl;

  localparam int P   = 18;
  localparam int BL  = 2;
  localparam int SUB = (P - BL) / 8;
  localparam logic [6:0] SEG7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk, rst, en;
  logic [2:0] bright;
  logic [4:0] in_v [6];
  logic [5:0] an;
  logic [7:0] seg;
  logic [2:0] cur_dig;
  logic       scan_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: activity flag, position within slot, slot index, per-slot captures.
  bit         act;
  int         m, d;
  int         cap_b;
  logic [4:0] cap_code;
  logic [4:0] snap [6];

  led_scan_ctrl #(
    .PRESCALE(P),
    .BLANK   (BL)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .bright_i   (bright),
    .in0_i      (in_v[0]),
    .in1_i      (in_v[1]),
    .in2_i      (in_v[2]),
    .in3_i      (in_v[3]),
    .in4_i      (in_v[4]),
    .in5_i      (in_v[5]),
    .an_o       (an),
    .seg_o      (seg),
    .cur_dig_o  (cur_dig),
    .scan_tick_o(scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit lz_blank(input int k);
`ifdef LED_LZB_EN
    if (k == 0) return 1'b0;
    for (int j = 5; j >= k; j--) if (snap[j] != 5'd0) return 1'b0;
    return 1'b1;
`else
    return (k < 0);
`endif
  endfunction

  function automatic logic [7:0] exp_seg();
    if (lz_blank(d)) return 8'hFF;
    return {~cap_code[4], SEG7[cap_code[3:0]]};
  endfunction

  task automatic capture();
    cap_b    = int'(bright);
    cap_code = in_v[d];
  endtask

  task automatic take_snap();
    for (int k = 0; k < 6; k++) snap[k] = in_v[k];
  endtask

  task automatic compare();
    bit         lit;
    logic [5:0] exp_an;
    lit    = act && m >= BL && m < BL + (cap_b + 1) * SUB;
    exp_an = lit ? ~(6'b1 << d) : 6'h3F;
    check("an", 32'(an), 32'(exp_an));
    check("cur_dig", 32'(cur_dig), act ? d : 0);
    check("scan_tick", 32'(scan_tick), 32'(act && m == 0));
    check("an_onehot", 32'($countones(~an) <= 1), 1);
    if (!act) check("seg_dark", 32'(seg), 32'hFF);
    else if (lit) check("seg", 32'(seg), 32'(exp_seg()));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      act = 1'b0; m = 0; d = 0;
    end else if (!act) begin
      if (en) begin
        act = 1'b1; m = 0; d = 0;
        capture();
        take_snap();
      end
    end else if (!en) begin
      act = 1'b0; m = 0; d = 0;
    end else begin
      m++;
      if (m == P) begin
        m = 0;
        d = (d + 1) % 6;
        capture();
        if (d == 5) take_snap();
      end
    end
    #1;
    compare();
  endtask

  task automatic run_until(input int dt, input int mt);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(act && d == dt && m == mt) && n < 300);
    check("reach_slot", 32'(act && d == dt && m == mt), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; bright = 3'd7;
    act = 1'b0; m = 0; d = 0; cap_b = 0; cap_code = '0;
    for (int k = 0; k < 6; k++) begin
      in_v[k] = 5'(k);
      snap[k] = '0;
    end
    step();
    step();
    rst = 1'b0;
    repeat (4) step();

    // Full brightness, digits 0..5
    en = 1'b1;
    run_until(0, 10);
    check("dig0_seg", 32'(seg), 32'hC0);
    run_until(5, 10);
    check("dig5_seg", 32'(seg), 32'h92);
    run_until(0, 5);

    // Dim: bright change mid-slot takes effect at the next slot
    bright = 3'd0;
    run_until(2, 3);
    check("dim_on", 32'(an), 32'h3B);
    step();
    check("dim_off", 32'(an), 32'h3F);
    run_until(0, 5);

    // Input tearing on slot 2
    bright  = 3'd7;
    in_v[2] = 5'h03;
    run_until(2, 5);
    in_v[2] = 5'h1A;
    run_until(2, 10);
    check("tear_hold", 32'(seg), 32'hB0);
    run_until(2, 10);
    check("tear_next", 32'(seg), 32'h08);

    // Enable drop mid-slot, then restart
    run_until(3, 7);
    en = 1'b0;
    step();
    check("en_drop_an", 32'(an), 32'h3F);
    repeat (3) step();
    en = 1'b1;
    repeat (3) step();
    check("reen_an", 32'(an), 32'h3E);

    // Asynchronous reset mid-slot
    run_until(1, 9);
    #2 rst = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'h3F);
    check("arst_seg", 32'(seg), 32'hFF);
    check("arst_dig", 32'(cur_dig), 0);
    en = 1'b0;
    step();
    #1 rst = 1'b0;
    repeat (4) step();

`ifdef LED_LZB_EN
    for (int k = 0; k < 6; k++) in_v[k] = 5'd0;
    en = 1'b1;
    repeat (2 * 6 * P) step();
    in_v[1] = 5'd7;
    repeat (2 * 6 * P) step();
    run_until(1, 5);
    check("lzb_dig1", 32'(seg), 32'hF8);
    run_until(3, 5);
    check("lzb_dig3", 32'(seg), 32'hFF);
`endif

    // Randomized operation
    en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (act && m >= 3 && m <= 15) begin
        if ($urandom_range(7) == 0) in_v[$urandom_range(5)] = 5'($urandom);
        if ($urandom_range(15) == 0) bright = 3'($urandom);
      end
      if (act && $urandom_range(249) == 0) en = 1'b0;
      else if (!act && $urandom_range(3) == 0) en = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Time-multiplexed scan controller for the 6-digit seven-segment bank. It takes the six 5-bit digit codes ({dp, hex}) produced by the banner/rotator logic and drives one shared active-low segment bus plus six active-low anode enables. Each digit is lit in turn, with a blanking dead-time between digits to prevent ghosting and a 3-bit brightness control using on-time duty.

Parameters:
N_DIG, 6, number of digits scanned; fixed at 6 in this revision.
PRESCALE, 50_000, clk cycles per digit slot (50 MHz gives 1 kHz per digit, 166 Hz frame); must satisfy PRESCALE >= BLANK + 8.
BLANK, 500, dead-time cycles at the start of each slot with all anodes off.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  scan enable; 0 forces the display dark
bright  in  3  brightness level; 0 is dimmest, 7 is full on
in0..in5  in  5 each  digit codes {dp, hex[3:0]}; in5 is the leftmost digit, in0 the rightmost
an  out  6  anode enables, active-low; an[k] lights digit k
seg  out  8  segments, active-low, ordered {dp, g, f, e, d, c, b, a}
cur_dig  out  3  index of the slot in progress (0..5)
scan_tick  out  1  one-cycle pulse on the first cycle of every slot

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, cnt=0, cur_dig=0, an=6'h3F, seg=8'hFF, scan_tick=0. All outputs are registered.
- Slot counter cnt runs 0..PRESCALE-1 and wraps to 0. On wrap, cur_dig increments and goes from 5 back to 0.
- Define SUB = (PRESCALE-BLANK)/8 (integer divide) and ON_END = BLANK + (bright+1)*SUB.
- FSM states and transitions:
  - IDLE: an and seg are all 1s. If en=1, go to BLANK next cycle with cnt=0 and cur_dig=0.
  - BLANK (cnt < BLANK): an=6'h3F. At cnt==0, latch the digit code in[cur_dig] into a hold register, so mid-slot input changes never tear the display. seg is driven from the decoded hold register. At cnt==BLANK-1, go to ON.
  - ON (BLANK <= cnt < ON_END): an=~(6'b1 << cur_dig). At cnt==ON_END-1, go to OFF. If cnt==PRESCALE-1 first, go to BLANK.
  - OFF (ON_END <= cnt < PRESCALE): an=6'h3F. At cnt==PRESCALE-1, go to BLANK.
- Output timing: scan_tick=1 in the cycle where the registered cnt==0 (registered output). An anode asserts on the cycle where cnt==BLANK.
- Decode of seg[6:0] (active-low gfedcba), hex 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E. seg[7]=~dp.
- bright is sampled once per slot, at cnt==0, so ON_END is stable for the whole slot.
- en falling mid-slot: the next cycle goes to IDLE with all outputs dark, cnt=0 and cur_dig=0. Re-enabling restarts at digit 0.
- rst asserted mid-operation: outputs go to their reset values immediately, without waiting for clk.
- Guarantee: at most one an bit is 0 in any cycle, and an is never 0 during BLANK.

Optional Feature:
LED_LZB_EN: enables leading-zero blanking.
- When defined: digit k (k = 5..1) is blanked (seg=8'hFF for its whole slot, anode still scanned) if its hex=0, its dp=0, and every higher digit is also blanked. Digit 0 is never blanked. The evaluation uses the snapshot of all six inputs taken at the start of the cur_dig=5 slot, so blanking is consistent across one frame.
- When undefined: zeros are displayed normally.

Decomposition:
- Package led_pkg holds: the scan state enum (IDLE, BLANK, ON, OFF), the 16-entry active-low segment constant table, N_DIG, and the SEG_OFF / AN_OFF constants.
- Sub-module hex_to_seg: combinational 5-bit {dp, hex} to 8-bit active-low seg decoder, instantiated once on the hold register.

Test Plan:
All scenarios use PRESCALE=18 and BLANK=2, so SUB=2.
- Reset check: rst=1 mid-slot -> same cycle an=6'h3F, seg=8'hFF, cur_dig=0. Release rst with en=0 -> outputs stay dark.
- Full-brightness scan: en=1, bright=7, in0..in5 = 0..5 -> for each k, an=~(1<<k) for 16 cycles, 2 dark cycles between digits; seg=8'hC0 for digit 0 and 8'h92 for digit 5. scan_tick fires every 18 cycles, and cur_dig goes 0..5 then back to 0.
- Dim mode: bright=0 -> each anode is low for exactly 2 cycles (cnt 2..3) per 18-cycle slot.
- Input tearing: change in2 from 5'h03 to 5'h1A at cnt=5 of slot 2 -> seg stays 8'hB0 for the rest of that slot. The next visit to slot 2 shows 8'h08 (A, dp on).
- en drop: en=0 at cnt=7 of slot 3 -> next cycle an=6'h3F. Re-enable -> 2 blank cycles, then digit 0 lights.
- LED_LZB_EN: inputs in5..in0 = 0,0,0,0,0,0 -> only digit 0 shows 8'hC0. With in5..in0 = 0,0,0,0,7,0 -> digits 5..2 show 8'hFF while digits 1 and 0 show 8'hF8 and 8'hC0.
